// File: rtl/wb_initiator.sv
// Wishbone classic initiator: turns one core load/store into one bus cycle.
// Optional bus-wait timeout is enabled by defining WB_INITIATOR_TIMEOUT_EN.
`timescale 1ns/1ps
module wb_initiator #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [29:0] wb_adr_o,
  output logic [3:0]  wb_sel_o,
  output logic [31:0] wb_dat_o,
  input  logic        wb_ack_i,
  input  logic [31:0] wb_dat_i
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUS = 2'd1, RESP = 2'd2} state_t;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
    $error("wb_initiator: TIMEOUT must be in 2..255");
  end

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic        cyc_q, cyc_d;
  logic        we_q, we_d;
  logic [3:0]  sel_q, sel_d;
  logic [31:0] dat_q, dat_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_err_q, rsp_err_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
`ifdef WB_INITIATOR_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
  logic [7:0]  tmo_q, tmo_d;
`endif

  function automatic logic [3:0] lane_sel(input logic [1:0] sz, input logic [1:0] off);
    case (sz)
      SZ_BYTE: lane_sel = 4'b0001 << off;
      SZ_HALF: lane_sel = 4'b0011 << off;
      default: lane_sel = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_dat(input logic [1:0] sz, input logic [31:0] wd);
    case (sz)
      SZ_BYTE: lane_dat = {4{wd[7:0]}};
      SZ_HALF: lane_dat = {2{wd[15:0]}};
      default: lane_dat = wd;
    endcase
  endfunction

  function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] off);
    case (sz)
      SZ_HALF: misaligned = off[0];
      SZ_WORD: misaligned = (off != 2'b00);
      default: misaligned = 1'b0;
    endcase
  endfunction

  // Shift the addressed lane down to bit 0, then extend to 32 bits.
  function automatic logic [31:0] load_data(input logic [1:0] sz, input logic uns,
                                            input logic [1:0] off, input logic [31:0] d);
    logic [31:0] lane;
    lane = d >> {off, 3'b000};
    case (sz)
      SZ_BYTE: load_data = {{24{~uns & lane[7]}}, lane[7:0]};
      SZ_HALF: load_data = {{16{~uns & lane[15]}}, lane[15:0]};
      default: load_data = lane;
    endcase
  endfunction

  assign req_ready = ~rst & en & (state_q == IDLE);

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    size_d      = size_q;
    uns_d       = uns_q;
    cyc_d       = cyc_q;
    we_d        = we_q;
    sel_d       = sel_q;
    dat_d       = dat_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = '0;
`ifdef WB_INITIATOR_TIMEOUT_EN
    tmo_d       = tmo_q;
`endif
    case (state_q)
      IDLE: begin
        if (req_valid && req_ready) begin
          addr_d = req_addr;
          size_d = req_size[1] ? SZ_WORD : req_size;
          uns_d  = req_unsigned;
          dat_d  = lane_dat(size_d, req_wdata);
          if (misaligned(size_d, req_addr[1:0])) begin
            // Rejected before the bus: report the error without a cycle.
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end else begin
            state_d = BUS;
            cyc_d   = 1'b1;
            we_d    = req_we;
            sel_d   = lane_sel(size_d, req_addr[1:0]);
`ifdef WB_INITIATOR_TIMEOUT_EN
            tmo_d   = 8'd0;
`endif
          end
        end
      end
      BUS: begin
        if (wb_ack_i) begin
          state_d     = RESP;
          cyc_d       = 1'b0;
          we_d        = 1'b0;
          sel_d       = 4'b0000;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = we_q ? 32'd0 : load_data(size_q, uns_q, addr_q[1:0], wb_dat_i);
        end
`ifdef WB_INITIATOR_TIMEOUT_EN
        else if (tmo_q == TMO_LAST) begin
          state_d     = RESP;
          cyc_d       = 1'b0;
          we_d        = 1'b0;
          sel_d       = 4'b0000;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
`endif
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      size_q      <= '0;
      uns_q       <= 1'b0;
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      sel_q       <= '0;
      dat_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
`ifdef WB_INITIATOR_TIMEOUT_EN
      tmo_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      cyc_q       <= cyc_d;
      we_q        <= we_d;
      sel_q       <= sel_d;
      dat_q       <= dat_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
`ifdef WB_INITIATOR_TIMEOUT_EN
      tmo_q       <= tmo_d;
`endif
    end
  end

  assign wb_cyc_o  = cyc_q;
  assign wb_stb_o  = cyc_q;
  assign wb_we_o   = we_q;
  assign wb_sel_o  = sel_q;
  assign wb_dat_o  = dat_q;
  assign wb_adr_o  = addr_q[31:2];
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_wb_initiator.sv
// Scoreboard bench for wb_initiator: byte-level reference model, random and directed traffic.
`timescale 1ns/1ps
module tb_wb_initiator;
  logic        clk = 1'b0, rst = 1'b1, en = 1'b1;
  logic        req_valid = 1'b0, req_we = 1'b0, req_unsigned = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [1:0]  req_size = '0;
  logic        req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        wb_cyc_o, wb_stb_o, wb_we_o, wb_ack_i;
  logic [29:0] wb_adr_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_dat_o, wb_dat_i;

  logic        stall = 1'b0, zero_wait = 1'b0, ack_rnd = 1'b0, spur = 1'b0;
  logic        pre_en = 1'b0;
  logic [3:0]  pre_idx = '0;
  logic [31:0] pre_val = '0;
  logic [31:0] rmem [16];
  bit   [31:0] ref_mem [16];
  int          checks = 0, errors = 0, cyc_cnt = 0;

  typedef struct {logic [29:0] adr; logic we; logic [3:0] sel; logic [31:0] dat;} bus_t;
  typedef struct {logic [31:0] rdata; logic err; int lat; int acc;} rsp_t;
  bus_t bus_q[$];
  rsp_t rsp_q[$];

  wb_initiator #(.TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .en(en), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o), .wb_adr_o(wb_adr_o),
    .wb_sel_o(wb_sel_o), .wb_dat_o(wb_dat_o), .wb_ack_i(wb_ack_i), .wb_dat_i(wb_dat_i)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Responder: 16-word memory aliased over the address space, random wait states.
  assign wb_ack_i = (wb_cyc_o & wb_stb_o & ack_rnd & ~stall) | spur;
  assign wb_dat_i = rmem[wb_adr_o[3:0]];
  always @(posedge clk) begin
    if (pre_en) rmem[pre_idx] <= pre_val;
    else if (wb_cyc_o && wb_stb_o && wb_ack_i && wb_we_o)
      for (int i = 0; i < 4; i++)
        if (wb_sel_o[i]) rmem[wb_adr_o[3:0]][8*i +: 8] <= wb_dat_o[8*i +: 8];
  end
  initial forever begin
    @(negedge clk);
    ack_rnd = zero_wait | ($urandom_range(0, 2) == 0);
    spur    = !wb_cyc_o && !rst && ($urandom_range(0, 3) == 0);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic fail(input string name, input logic [31:0] act);
    checks++;
    errors++;
    $display("FAIL %s actual=%h expected=nothing", name, act);
  endtask

  // Monitor: pops expectations when the DUT starts a bus cycle or pulses a response.
  initial begin
    bus_t cur;
    rsp_t r;
    bit in_txn = 0;
    cur = '{default: '0};
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (wb_cyc_o) begin
          if (!in_txn) begin
            if (bus_q.size() == 0) fail("unexpected_cyc", {2'b00, wb_adr_o});
            else cur = bus_q.pop_front();
            in_txn = 1;
          end
          chk("stb", wb_stb_o, 1'b1);
          chk("adr", wb_adr_o, cur.adr);
          chk("we", wb_we_o, cur.we);
          chk("sel", wb_sel_o, cur.sel);
          if (cur.we) chk("dat", wb_dat_o, cur.dat);
        end else begin
          in_txn = 0;
          chk("idle_bus", {wb_stb_o, wb_we_o, wb_sel_o}, 32'd0);
        end
        if (rsp_valid) begin
          if (rsp_q.size() == 0) fail("unexpected_rsp", rsp_rdata);
          else begin
            r = rsp_q.pop_front();
            chk("rdata", rsp_rdata, r.rdata);
            chk("err", rsp_err, r.err);
            if (r.lat >= 0) chk("latency", cyc_cnt - r.acc, r.lat);
          end
        end
      end
    end
  end

  task automatic preload(input int idx, input logic [31:0] val);
    ref_mem[idx] = val;
    pre_idx = idx[3:0];
    pre_val = val;
    pre_en  = 1'b1;
    @(posedge clk);
    #1 pre_en = 1'b0;
  endtask

  // Drives one request and, at acceptance, pushes what the bus and response must look like.
  task automatic issue(input logic we, input logic [31:0] a, input logic [1:0] sz, input logic u,
                       input logic [31:0] wd, input bit chk_lat, input bit tmo);
    int n, nb, off, idx;
    logic [3:0] sel;
    logic [31:0] dat;
    logic [63:0] v;
    bus_t b;
    rsp_t r;
    @(negedge clk);
    en = 1'b1; req_valid = 1'b1; req_we = we; req_addr = a;
    req_size = sz; req_unsigned = u; req_wdata = wd;
    n = 0;
    while (!req_ready && n < 300) begin @(negedge clk); n++; end
    if (!req_ready) begin fail("accept_timeout", a); req_valid = 1'b0; return; end
    nb  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    off = int'(a[1:0]);
    idx = int'(a[5:2]);
    r.acc = cyc_cnt; r.lat = -1; r.rdata = '0; r.err = 1'b0;
    if ((nb == 2 && off % 2 != 0) || (nb == 4 && off != 0)) begin
      r.err = 1'b1;
      r.lat = 1;
    end else begin
      sel = '0;
      for (int k = 0; k < nb; k++) sel[off + k] = 1'b1;
      for (int i = 0; i < 4; i++) dat[8*i +: 8] = wd[8*(i % nb) +: 8];
      b.adr = a[31:2]; b.we = we; b.sel = sel; b.dat = dat;
      bus_q.push_back(b);
      if (chk_lat) r.lat = 2;
      if (tmo) r.err = 1'b1;
      else if (we) begin
        for (int k = 0; k < nb; k++) ref_mem[idx][8*(off + k) +: 8] = wd[8*k +: 8];
      end else begin
        v = '0;
        for (int k = 0; k < nb; k++) v[8*k +: 8] = ref_mem[idx][8*(off + k) +: 8];
        if (!u && v[8*nb - 1]) v = v | ~((64'd1 << (8*nb)) - 64'd1);
        r.rdata = v[31:0];
      end
    end
    rsp_q.push_back(r);
    @(posedge clk);
    #1 req_valid = 1'b0;
    if ($urandom_range(0, 4) == 0) en = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (rsp_q.size() != 0 && n < 500) begin @(negedge clk); n++; end
    if (rsp_q.size() != 0) fail("drain_timeout", rsp_q.size());
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_cyc", wb_cyc_o, 1'b0);
    chk("rst_async_stb", wb_stb_o, 1'b0);
    chk("rst_async_rsp", rsp_valid, 1'b0);
    rsp_q.delete();
    bus_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    stall = 1'b0;
    rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    for (int i = 0; i < 16; i++) preload(i, $urandom());
    @(negedge clk);
    chk("rst_ctrl", {req_ready, rsp_valid, rsp_err, wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o}, 32'd0);
    chk("rst_rdata", rsp_rdata, 32'd0);
    chk("rst_dat", wb_dat_o, 32'd0);
    chk("rst_adr", wb_adr_o, 32'd0);
    rst = 1'b0;
    zero_wait = 1'b1;

    preload(1, 32'h1234_5678);
    issue(1'b0, 32'h0040_0004, 2'd2, 1'b0, 32'd0, 1'b1, 1'b0);
    drain();
    issue(1'b1, 32'h8000_0003, 2'd0, 1'b0, 32'h0000_00AB, 1'b1, 1'b0);
    issue(1'b0, 32'h8000_0000, 2'd2, 1'b0, 32'd0, 1'b1, 1'b0);
    drain();
    preload(0, 32'h8001_0000);
    issue(1'b0, 32'h8000_0002, 2'd1, 1'b0, 32'd0, 1'b1, 1'b0);
    issue(1'b0, 32'h8000_0002, 2'd1, 1'b1, 32'd0, 1'b1, 1'b0);
    issue(1'b0, 32'h8000_0001, 2'd2, 1'b0, 32'd0, 1'b1, 1'b0);
    issue(1'b0, 32'h8000_0003, 2'd1, 1'b0, 32'd0, 1'b1, 1'b0);
    issue(1'b1, 32'h8000_0008, 2'd3, 1'b0, 32'hCAFE_F00D, 1'b1, 1'b0);
    issue(1'b0, 32'h8000_0009, 2'd0, 1'b0, 32'd0, 1'b1, 1'b0);
    drain();

    @(negedge clk);
    en = 1'b0; req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h8000_0004; req_size = 2'd2;
    repeat (5) begin
      @(negedge clk);
      chk("ready_when_disabled", req_ready, 1'b0);
      chk("no_cyc_when_disabled", wb_cyc_o, 1'b0);
    end
    req_valid = 1'b0; en = 1'b1;

    zero_wait = 1'b0;
    repeat (200) begin
      logic [31:0] a;
      a = $urandom();
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      issue(1'($urandom_range(0, 1)), a, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            $urandom(), 1'b0, 1'b0);
    end
    drain();

    zero_wait = 1'b1;
    stall = 1'b1;
`ifdef WB_INITIATOR_TIMEOUT_EN
    issue(1'b0, 32'h1000_0000, 2'd2, 1'b0, 32'd0, 1'b0, 1'b1);
    k = 0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (wb_cyc_o) k++;
      else break;
    end
    chk("timeout_cyc_cycles", k, 32'd16);
    drain();
    stall = 1'b0;
`else
    issue(1'b0, 32'h1000_0000, 2'd2, 1'b0, 32'd0, 1'b0, 1'b0);
    k = 0;
    repeat (40) begin
      @(negedge clk);
      if (wb_cyc_o) k++;
    end
    chk("stall_cyc_held", k, 32'd40);
    pulse_reset();
`endif

    stall = 1'b1;
    issue(1'b0, 32'h8000_0010, 2'd2, 1'b0, 32'd0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    pulse_reset();
    issue(1'b0, 32'h8000_0010, 2'd2, 1'b0, 32'd0, 1'b1, 1'b0);
    drain();
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
